// File: rtl/sigmoid_act_pipe.sv
// Pipelined sigmoid activation: signed fixed-point x in, sigmoid(x) as unsigned Q0.8 out.
// Elastic valid/ready pipeline with a single global advance; optional linear interpolation stage.
module sigmoid_act_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int INTERP = 0,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_y,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int FB  = FRAC_W - 4;
  localparam int FBW = (FB > 0) ? FB : 1;

  // round(256 * sigmoid(k/16)), clipped to 255, k = 0..96
  localparam logic [7:0] TBL [97] = '{
    8'd128, 8'd132, 8'd136, 8'd140, 8'd144, 8'd148, 8'd152, 8'd156,
    8'd159, 8'd163, 8'd167, 8'd170, 8'd174, 8'd177, 8'd181, 8'd184,
    8'd187, 8'd190, 8'd193, 8'd196, 8'd199, 8'd202, 8'd204, 8'd207,
    8'd209, 8'd212, 8'd214, 8'd216, 8'd218, 8'd220, 8'd222, 8'd224,
    8'd225, 8'd227, 8'd229, 8'd230, 8'd232, 8'd233, 8'd234, 8'd235,
    8'd237, 8'd238, 8'd239, 8'd240, 8'd241, 8'd241, 8'd242, 8'd243,
    8'd244, 8'd245, 8'd245, 8'd246, 8'd246, 8'd247, 8'd248, 8'd248,
    8'd248, 8'd249, 8'd249, 8'd250, 8'd250, 8'd250, 8'd251, 8'd251,
    8'd251, 8'd252, 8'd252, 8'd252, 8'd252, 8'd253, 8'd253, 8'd253,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254,
    8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255
  };

  function automatic logic [7:0] lut(input logic [6:0] k, input logic sat);
    if (sat || (k > 7'd96)) lut = 8'd255;
    else                    lut = TBL[k];
  endfunction

  // Handshake: a beat moves on valid && ready at either port. Every stage
  // shifts together when adv is high; adv drops only while a result is held.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic [DATA_W:0] xe, a, idx_full;
  logic [FBW-1:0]  fr;

  always_comb begin
    xe       = {in_x[DATA_W-1], in_x};
    a        = in_x[DATA_W-1] ? -xe : xe;
    idx_full = a >> FB;
    fr       = '0;
    if (FB > 0) fr = a[FBW-1:0];
  end

  logic             s1_valid, s1_s, s1_sat;
  logic [6:0]       s1_idx;
  logic [FBW-1:0]   s1_fr;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_sat   <= 1'b0;
      s1_idx   <= '0;
      s1_fr    <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_s     <= in_x[DATA_W-1];
      s1_sat   <= (idx_full >= (DATA_W+1)'(96));
      s1_idx   <= idx_full[6:0];
      s1_fr    <= fr;
      s1_tag   <= in_tag;
    end
  end

  logic             fin_valid, fin_s;
  logic [7:0]       fin_p;
  logic [TAG_W-1:0] fin_tag;

  generate
    if (INTERP != 0) begin : g_interp
      logic             s2_valid, s2_s;
      logic [7:0]       s2_p, s2_q;
      logic [FBW-1:0]   s2_fr;
      logic [TAG_W-1:0] s2_tag;
      logic [7+FBW:0]   prod;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_s     <= 1'b0;
          s2_p     <= '0;
          s2_q     <= '0;
          s2_fr    <= '0;
          s2_tag   <= '0;
        end else if (adv) begin
          s2_valid <= s1_valid;
          s2_s     <= s1_s;
          s2_p     <= lut(s1_idx, s1_sat);
          s2_q     <= lut(s1_idx + 7'd1, s1_sat);
          s2_fr    <= s1_fr;
          s2_tag   <= s1_tag;
        end
      end

      // Table is monotonic, so q - p never underflows and p + step <= q.
      always_comb begin
        prod = (8+FBW)'(s2_q - s2_p) * (8+FBW)'(s2_fr);
      end

      assign fin_valid = s2_valid;
      assign fin_s     = s2_s;
      assign fin_p     = s2_p + 8'(prod >> FB);
      assign fin_tag   = s2_tag;
    end else begin : g_direct
      logic unused_fr;
      assign unused_fr = ^s1_fr;
      assign fin_valid = s1_valid;
      assign fin_s     = s1_s;
      assign fin_p     = lut(s1_idx, s1_sat);
      assign fin_tag   = s1_tag;
    end
  endgenerate

  // Negative inputs use sigmoid(-x) = 1 - sigmoid(x); p >= 128 keeps 256 - p in 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_y   <= {8'h00, fin_s ? 8'(9'd256 - {1'b0, fin_p}) : fin_p};
        out_tag <= fin_tag;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_act_pipe.sv
// Self-checking bench for sigmoid_act_pipe: one instance per INTERP setting,
// directed vectors with hand-computed results plus a random sweep against a model.
module tb_sigmoid_act_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [1:0][15:0] in_x, out_y;
  logic [1:0][3:0]  in_tag, out_tag;

  sigmoid_act_pipe #(.DATA_W(16), .FRAC_W(8), .INTERP(0), .TAG_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]), .in_tag(in_tag[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]), .out_tag(out_tag[0])
  );

  sigmoid_act_pipe #(.DATA_W(16), .FRAC_W(8), .INTERP(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]), .in_tag(in_tag[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]), .out_tag(out_tag[1])
  );

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  int          tbl [97];
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  logic [15:0] obs0[$];
  logic [15:0] obs1[$];
  bit          cap_en = 1'b0;
  bit          rnd_done;

  logic [15:0] vec_x [8] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080,
                             16'h0600, 16'hFA00, 16'h0010, 16'hFFF0};
  logic [15:0] vec_y [8] = '{16'd128, 16'd187, 16'd69, 16'd159,
                             16'd255, 16'd1, 16'd132, 16'd124};
  logic [15:0] sat_x [4] = '{16'h0600, 16'h7FFF, 16'hFA00, 16'h8000};
  logic [15:0] sat_y [4] = '{16'd255, 16'd255, 16'd1, 16'd1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input int interp);
    int xi, ai, idx, fr, p, q;
    xi  = int'($signed(x));
    ai  = (xi < 0) ? -xi : xi;
    idx = ai >> 4;
    fr  = ai & 15;
    if (idx >= 96) p = 255;
    else begin
      p = tbl[idx];
      if (interp != 0) begin
        q = tbl[idx + 1];
        p = p + (((q - p) * fr) >> 4);
      end
    end
    return 16'((xi < 0) ? (256 - p) : p);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic pop_check(input int d);
    logic [19:0] got, e;
    if (rst || !out_valid[d] || !out_ready[d]) return;
    got = {out_tag[d], out_y[d]};
    if (cap_en) begin
      if (d == 0) obs0.push_back(out_y[0]);
      else        obs1.push_back(out_y[1]);
    end
    check($sformatf("d%0d_exp_pending", d), 32'(qsize(d) != 0), 32'd1);
    if (qsize(d) != 0) begin
      e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("d%0d_out_tag_y", d), 32'(got), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    pop_check(0);
    pop_check(1);
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send(input int d, input logic [15:0] x, input logic [3:0] tag,
                      input logic [15:0] y, input bit track);
    int n;
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    in_tag[d]   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 200) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("d%0d_in_ready_wait", d), 32'(in_ready[d]), 32'd1);
    if (track) begin
      if (d == 0) exp_q0.push_back({tag, y});
      else        exp_q1.push_back({tag, y});
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic lat_test(input int d, input logic [15:0] x, input logic [15:0] y, input int lat);
    int n;
    send(d, x, 4'(lat), y, 1'b1);
    n = 1;
    @(negedge clk);
    while (!out_valid[d] && n < 10) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("d%0d_latency_x%0h", d, x), 32'(n), 32'(lat));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("d%0d_drain", d), 32'(qsize(d)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] x, held;
    logic [3:0]  held_tag;
    for (int k = 0; k < 97; k++) begin
      real r;
      r = 256.0 / (1.0 + $exp(-real'(k) / 16.0));
      tbl[k] = $rtoi(r + 0.5);
      if (tbl[k] > 255) tbl[k] = 255;
    end
    in_valid  = '0;
    in_x      = '0;
    in_tag    = '0;
    out_ready = 2'b11;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_out_valid", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("d%0d_rst_out_y", d), 32'(out_y[d]), 32'd0);
      check($sformatf("d%0d_rst_out_tag", d), 32'(out_tag[d]), 32'd0);
      check($sformatf("d%0d_rst_in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    @(posedge clk);
    #1;

    // basic values and latency, table lookup only
    for (int i = 0; i < 4; i++) lat_test(0, vec_x[i], vec_y[i], 2);
    // interpolation: T[0]=128,T[1]=132,T[2]=136
    lat_test(1, 16'h0008, 16'd130, 3);
    lat_test(1, 16'h0018, 16'd134, 3);
    lat_test(1, 16'h0010, 16'd132, 3);
    lat_test(1, 16'hFFE8, 16'd122, 3);

    // saturation, including the most negative input
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) send(d, sat_x[i], 4'(i), sat_y[i], 1'b1);
      drain(d);
    end

    // backpressure: 8 tagged samples, out_ready low mid-stream
    for (int d = 0; d < 2; d++) begin
      fork
        begin
          for (int i = 0; i < 8; i++) send(d, vec_x[i], 4'(i + 3), vec_y[i], 1'b1);
        end
        begin
          repeat (4) @(posedge clk);
          #1;
          out_ready[d] = 1'b0;
          @(negedge clk);
          held     = out_y[d];
          held_tag = out_tag[d];
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("d%0d_bp_in_ready", d), 32'(in_ready[d]), 32'd0);
            check($sformatf("d%0d_bp_out_valid", d), 32'(out_valid[d]), 32'd1);
            check($sformatf("d%0d_bp_hold", d), 32'({out_tag[d], out_y[d]}), 32'({held_tag, held}));
          end
          @(posedge clk);
          #1;
          out_ready[d] = 1'b1;
        end
      join
      drain(d);
    end

    // reset with two samples in flight in the interpolating pipe
    send(1, 16'h0100, 4'hA, 16'd0, 1'b0);
    send(1, 16'hFF00, 4'hB, 16'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("d1_midrst_out_valid", 32'(out_valid[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("d1_midrst_no_output", 32'(out_valid[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    lat_test(1, 16'h0000, 16'd128, 3);

    // symmetry: 256 - y(x) == y(-x)
    for (int d = 0; d < 2; d++) begin
      obs0.delete();
      obs1.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        x = 16'($urandom);
        if (x == 16'h8000) x = 16'h7F00;
        send(d, x, 4'(i), model(x, d), 1'b1);
        send(d, 16'd0 - x, 4'(i), model(16'd0 - x, d), 1'b1);
      end
      drain(d);
      cap_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (d == 0) check("d0_symmetry", 32'(16'd256 - obs0[2*i]), 32'(obs0[2*i+1]));
        else        check("d1_symmetry", 32'(16'd256 - obs1[2*i]), 32'(obs1[2*i+1]));
      end
    end

    // random sweep with random valid gaps and backpressure
    for (int d = 0; d < 2; d++) begin
      rnd_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 5000; i++) begin
            x = 16'($urandom);
            if ($urandom_range(0, 2) == 0) x = 16'($urandom_range(0, 4095)) - 16'd2048;
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send(d, x, 4'($urandom), model(x, d), 1'b1);
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clk);
            #1;
            out_ready[d] = ($urandom_range(0, 3) != 0);
          end
          out_ready[d] = 1'b1;
        end
      join
      drain(d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
